// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART decoder: FWFT byte+parity storage with
// overflow, parity-error counting and an idle-line timeout for partial bursts.
module uart_rx_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 19096
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rx_perr,
  input  logic          rd_en,
  input  logic          clr_ovf,
  input  logic          clr_perr_cnt,
  output logic [7:0]    rd_data,
  output logic          rd_perr,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    perr_cnt,
  output logic          rx_timeout
);

  localparam int          IW       = ($clog2(TIMEOUT + 1) > 15) ? $clog2(TIMEOUT + 1) : 15;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    perr_cnt_q, perr_cnt_d;
  logic [IW-1:0] idle_q, idle_d;

  logic          do_push, do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign rd_data    = mem_q[rp_q][7:0];
  assign rd_perr    = mem_q[rp_q][8];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign perr_cnt   = perr_cnt_q;
  assign rx_timeout = (idle_q == IDLE_MAX) && !empty;

  // A pop frees the slot the concurrent push lands in, so full only blocks a lone push.
  assign do_pop  = rd_en && !empty;
  assign do_push = rx_done && (!full || do_pop);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    overflow_d = overflow_q;
    perr_cnt_d = perr_cnt_q;
    idle_d     = idle_q;

    if (do_push) begin
      mem_d[wp_q] = {rx_perr, rx_data};
      wp_d        = wp_q + 1'b1;
    end
    if (do_pop) rp_d = rp_q + 1'b1;

    if (rx_done && full && !rd_en) overflow_d = 1'b1;
    else if (clr_ovf)              overflow_d = 1'b0;

    if (do_push && rx_perr) begin
      if (clr_perr_cnt)              perr_cnt_d = 8'd1;
      else if (perr_cnt_q != 8'hFF)  perr_cnt_d = perr_cnt_q + 8'd1;
    end else if (clr_perr_cnt) begin
      perr_cnt_d = 8'd0;
    end

    if (do_push || do_pop || empty) idle_d = '0;
    else if (idle_q != IDLE_MAX)    idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: storage is reset too, so rd_data reads 0 after reset rather than X.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      perr_cnt_q <= '0;
      idle_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      perr_cnt_q <= perr_cnt_d;
      idle_q     <= idle_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 19096;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        rx_perr = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        clr_perr_cnt = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_perr;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overflow;
  logic [7:0]  perr_cnt;
  logic        rx_timeout;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_done(rx_done),
    .rx_perr(rx_perr), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .clr_perr_cnt(clr_perr_cnt), .rd_data(rd_data), .rd_perr(rd_perr),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .perr_cnt(perr_cnt), .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {perr, byte} plus the sticky/counting state.
  logic [8:0] mq[$];
  bit         m_ovf;
  int         m_perr;
  longint     cyc, last_act;
  bit         check_en = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mq.delete();
      m_ovf    = 0;
      m_perr   = 0;
      last_act = cyc;
    end else begin
      bit pop, push;
      cyc++;
      pop  = rd_en && (mq.size() > 0);
      push = rx_done && ((mq.size() < DEPTH) || pop);
      if (rx_done && mq.size() == DEPTH && !rd_en) m_ovf = 1;
      else if (clr_ovf)                            m_ovf = 0;
      if (push && rx_perr) m_perr = clr_perr_cnt ? 1 : ((m_perr < 255) ? m_perr + 1 : 255);
      else if (clr_perr_cnt) m_perr = 0;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({rx_perr, rx_data});
      if (push || pop) last_act = cyc;
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en && nrst) begin
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      check("perr_cnt", perr_cnt, m_perr);
      check("rx_timeout", rx_timeout, (mq.size() > 0) && (cyc - last_act >= TIMEOUT));
      if (mq.size() > 0) begin
        check("rd_data", rd_data, mq[0][7:0]);
        check("rd_perr", rd_perr, mq[0][8]);
      end
    end
  end

  task automatic tick(input bit d, input logic [7:0] b, input bit pe, input bit rd,
                      input bit co = 0, input bit cp = 0);
    rx_done = d; rx_data = b; rx_perr = pe; rd_en = rd;
    clr_ovf = co; clr_perr_cnt = cp;
    @(posedge clk);
    @(negedge clk);
    rx_done = 0; rd_en = 0; clr_ovf = 0; clr_perr_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq1 [4];
    seq1 = '{8'hFA, 8'hDE, 8'hDA, 8'hE1};
    cyc = 0; last_act = 0;

    #13;
    check("rst rd_data", rd_data, 8'h00);
    check("rst rd_perr", rd_perr, 1'b0);
    check("rst empty", empty, 1'b1);
    check("rst full", full, 1'b0);
    check("rst count", count, 0);
    check("rst overflow", overflow, 1'b0);
    check("rst perr_cnt", perr_cnt, 8'h00);
    check("rst timeout", rx_timeout, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    check_en = 1;

    // In-order delivery.
    for (int i = 0; i < 4; i++) tick(1, seq1[i], 0, 0);
    check("t1 count", count, 4);
    check("t1 head", rd_data, 8'hFA);
    for (int i = 0; i < 4; i++) begin
      check("t1 pop data", rd_data, seq1[i]);
      tick(0, 8'h00, 0, 1);
    end
    check("t1 empty", empty, 1'b1);
    check("t1 count0", count, 0);

    // Parity errors.
    tick(1, 8'hDA, 1, 0);
    tick(1, 8'h1E, 1, 0);
    check("t2 perr_cnt", perr_cnt, 8'd2);
    check("t2 rd_perr0", rd_perr, 1'b1);
    tick(0, 8'h00, 0, 1);
    check("t2 rd_perr1", rd_perr, 1'b1);
    check("t2 rd_data1", rd_data, 8'h1E);
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);
    check("t2 perr clr", perr_cnt, 8'd0);

    // Overflow: 17 pushes, 0x10 lost.
    for (int i = 0; i <= 16; i++) tick(1, 8'(i), 0, 0);
    check("t3 full", full, 1'b1);
    check("t3 count", count, 16);
    check("t3 overflow", overflow, 1'b1);
    tick(0, 8'h00, 0, 0, 1, 0);
    check("t3 ovf clr", overflow, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("t3 pop data", rd_data, 8'(i));
      tick(0, 8'h00, 0, 1);
    end
    check("t3 drained", empty, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) tick(1, 8'(8'h80 + i), 0, 0);
    tick(1, 8'hAA, 0, 1);
    check("t4 count", count, 16);
    check("t4 overflow", overflow, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t4 last", rd_data, 8'hAA);
      tick(0, 8'h00, 0, 1);
    end

    // Idle timeout.
    tick(1, 8'h55, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(0, 8'h00, 0, 0);
    check("t5 not yet", rx_timeout, 1'b0);
    tick(0, 8'h00, 0, 0);
    check("t5 timeout", rx_timeout, 1'b1);
    tick(0, 8'h00, 0, 1);
    check("t5 dropped", rx_timeout, 1'b0);
    check("t5 empty", empty, 1'b1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) tick(1, 8'(8'h20 + i), 1, 0);
    check("t6 count5", count, 5);
    #2 nrst = 1'b0;
    #1;
    check("t6 rst count", count, 0);
    check("t6 rst empty", empty, 1'b1);
    check("t6 rst rd_data", rd_data, 8'h00);
    check("t6 rst perr_cnt", perr_cnt, 8'h00);
    @(negedge clk);
    nrst = 1'b1;
    tick(1, 8'h3C, 0, 0);
    check("t6 rd_data", rd_data, 8'h3C);
    check("t6 count1", count, 1);

    // Random traffic with varying push/pop pressure.
    for (int seg = 0; seg < 12; seg++) begin
      int pp, rp;
      pp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++)
        tick($urandom_range(0, 99) < pp, 8'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 99) < rp, $urandom_range(0, 29) == 0,
             $urandom_range(0, 39) == 0);
    end

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the UART Decoder.
- Captures each byte the Decoder completes, together with that byte's parity-error flag, into a FIFO.
- Presents the buffered bytes to the core's memory-mapped UART register interface as first-word-fall-through data with status flags.
- Also tracks overflow, counts parity errors and detects an idle-line timeout, so software can drain partial bursts.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 2 to 256.
- AW, 4, pointer width; equals log2(DEPTH).
- TIMEOUT, 19096, idle cycles before rx_timeout asserts (about 4 frames at 115200 bps with a 50 MHz clock).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the Decoder; valid only while rx_done=1.
- rx_done  in  1  single-cycle pulse: the Decoder has completed a frame.
- rx_perr  in  1  parity-error flag for the current frame; sampled with rx_done.
- rd_en  in  1  pop request from the register interface.
- clr_ovf  in  1  clears the sticky overflow flag.
- clr_perr_cnt  in  1  clears the parity-error counter.
- rd_data  out  8  head entry's byte.
- rd_perr  out  1  head entry's parity-error flag.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  number of occupied entries, 0 to DEPTH.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- perr_cnt  out  8  saturating count of accepted bytes that had rx_perr=1.
- rx_timeout  out  1  FIFO is non-empty and has been idle for TIMEOUT cycles.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; the ports are named clk and nrst.
- Reset values: rd_data=0, rd_perr=0, empty=1, full=0, count=0, overflow=0, perr_cnt=0, rx_timeout=0. Pointers and idle counter are 0; storage is cleared to 0.
- Reset mid-operation: all contents are discarded immediately, with no handshake.
- Storage: DEPTH x 9 bits ({perr, byte}). Write pointer wp and read pointer rp are AW bits and wrap modulo DEPTH. count is a separate AW+1-bit register.
- Push: on a clock edge with rx_done=1, and either not full or a pop in the same cycle, {rx_perr, rx_data} is written at wp and wp increments.
- Pop: on a clock edge with rd_en=1 and not empty, rp increments.
- Pop on empty: ignored with no side effects; this includes a simultaneous push to an empty FIFO, where only the push occurs.
- Read data (FWFT): rd_data and rd_perr always reflect storage[rp] combinationally, so they are valid whenever empty=0. After a pop they show the next entry one cycle later.
- Flag timing: count, empty and full update on the same edge as the push or pop. Simultaneous push and pop leaves count unchanged.
- Overflow: rx_done=1 while full, with no pop that cycle, drops the byte and sets overflow. The dropped byte does not affect perr_cnt. When overflow set and clr_ovf occur in the same cycle, set wins.
- perr_cnt: increments on each accepted push with rx_perr=1 and saturates at 255. clr_perr_cnt clears it; a simultaneous increment wins, giving a value of 1.
- Idle counter (15 bits minimum, saturating at TIMEOUT):
  - cleared on any accepted push, any effective pop, or while empty;
  - otherwise increments each cycle.
  - rx_timeout = (idle counter == TIMEOUT) && !empty. It is a level that stays high until the next push or pop.
- No combinational path from rx_done or rd_en to any output except through registered state; rd_data depends only on rp and storage.
- Latency: a byte pushed at edge N is visible on rd_data with empty=0 after edge N, i.e. from cycle N+1.

Test Plan:
- Reset, then push 0xFA, 0xDE, 0xDA, 0xE1 (rx_perr=0) on separate rx_done pulses -> count=4; rd_data=0xFA. Four pops -> reads 0xFA, 0xDE, 0xDA, 0xE1 in order; empty=1, count=0.
- Push 0xDA with rx_perr=1, then 0x1E with rx_perr=1 -> perr_cnt=2; rd_perr=1 at each head. Pulse clr_perr_cnt -> perr_cnt=0.
- Push 17 bytes 0x00..0x10 with no pops (DEPTH=16) -> full=1, count=16, overflow=1; pops return 0x00..0x0F and 0x10 is lost. clr_ovf -> overflow=0.
- FIFO full, then rx_done=1 with 0xAA and rd_en=1 in the same cycle -> count stays 16, overflow stays 0; 0xAA is the last entry read.
- Push one byte 0x55, then idle -> rx_timeout rises exactly TIMEOUT cycles after the push (19096). A pop drops it the next cycle and empty=1.
- Assert nrst=0 asynchronously mid-stream with count=5 -> all outputs return to reset values without waiting for a clock edge. After release, pushing 0x3C gives rd_data=0x3C and count=1.
